// File: rtl/arm7_dp_sequencer_pkg.sv
// Shared encodings for the data-processing sequencer: datapath control word,
// FSM state and decode class types, plus the instruction classifier.
package arm7_dp_sequencer_pkg;

    typedef enum logic {ALU_WB_NONE, ALU_WB_REG_RD} alu_wb_t;
    typedef enum logic [1:0] {ADDR_NONE, ADDR_INCR, ADDR_ALU} addr_src_t;
    typedef enum logic [1:0] {B_NONE, B_IMM, B_REG_RM} b_src_t;
    typedef enum logic [1:0] {SHIFT_SRC_NONE, SHIFT_SRC_IMM, SHIFT_SRC_REG} shift_src_t;
    typedef enum logic [1:0] {SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR} shift_type_t;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        set_alu_flags;
        alu_wb_t     alu_writeback;
        addr_src_t   addr_bus_src;
        logic        incrementer_writeback;
        b_src_t      b_bus_source;
        logic [11:0] b_bus_imm;
        shift_src_t  shift_source;
        shift_type_t shift_type;
        logic [4:0]  shift_amount;
        logic        latch_shift_amt;
        logic        use_shift_latch;
    } control_t;

    typedef enum logic [2:0] {S_IDLE, S_EX, S_RS, S_EX2, S_UND, S_REF1, S_REF2} dp_seq_state_t;
    typedef enum logic [1:0] {CLASS_IMM, CLASS_RSI, CLASS_RSR, CLASS_UNDEF} dp_class_t;

    localparam control_t CONTROL_ZERO = '0;

    // Bus cycle that only advances the PC; used for condition fails and refills.
    localparam control_t CONTROL_NOP = '{
        alu_op:                4'h0,
        set_alu_flags:         1'b0,
        alu_writeback:         ALU_WB_NONE,
        addr_bus_src:          ADDR_INCR,
        incrementer_writeback: 1'b1,
        b_bus_source:          B_NONE,
        b_bus_imm:             12'h000,
        shift_source:          SHIFT_SRC_NONE,
        shift_type:            SHIFT_LSL,
        shift_amount:          5'd0,
        latch_shift_amt:       1'b0,
        use_shift_latch:       1'b0
    };

    function automatic dp_class_t dp_classify(input logic [31:0] word);
        dp_class_t c;
        c = CLASS_UNDEF;
        if (word[27:25] == 3'b001)
            c = CLASS_IMM;
        else if (word[27:25] == 3'b000 && !word[4])
            c = CLASS_RSI;
        else if (word[27:25] == 3'b000 && !word[7])
            c = CLASS_RSR;
        return c;
    endfunction

endpackage

// File: rtl/arm7_dp_decode.sv
// Combinational field decode of the latched data-processing instruction.
module arm7_dp_decode
    import arm7_dp_sequencer_pkg::*;
(
    input  logic [31:0] ir,
    output dp_class_t   dp_class,
    output logic [3:0]  alu_op,
    output logic        set_flags,
    output logic        wb_none,
    output logic        rd_is_pc
);

    logic unused_bits;
    assign unused_bits = ^{ir[31:28], ir[11:8], ir[3:0]};

    assign dp_class  = dp_classify(ir);
    assign alu_op    = ir[24:21];
    assign set_flags = ir[20];
    // TST/TEQ/CMP/CMN only update flags.
    assign wb_none   = (ir[24:23] == 2'b10);
    assign rd_is_pc  = (ir[15:12] == 4'hF);

endmodule

// File: rtl/arm7_dp_sequencer.sv
// Data-processing instruction sequencer: expands each accepted instruction
// into datapath control words, handling reg-shifts, cond-fail NOPs and PC refill.
//
// state  | meaning
// S_IDLE | no instruction, all-zero control
// S_EX   | single-cycle IMM/RSI execute
// S_RS   | RSR cycle 1, latch shift amount from Rs
// S_EX2  | RSR cycle 2, execute with latched shift
// S_UND  | undefined encoding, NOP + undef pulse
// S_REF1 | pipeline refill after PC write, not ready
// S_REF2 | pipeline refill, ready for next
module arm7_dp_sequencer
    import arm7_dp_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  cond,
    input  logic        cond_pass,
    output control_t    control,
    output logic        flush,
    output logic        undef
);

    dp_seq_state_t state, next_state, entry_state;
    logic [31:0]   ir;
    dp_class_t     dp_class;
    logic [3:0]    alu_op;
    logic          set_flags, wb_none, rd_is_pc;
    control_t      ex_word, rs_word, ex2_word;

    arm7_dp_decode u_decode (
        .ir        (ir),
        .dp_class  (dp_class),
        .alu_op    (alu_op),
        .set_flags (set_flags),
        .wb_none   (wb_none),
        .rd_is_pc  (rd_is_pc)
    );

    assign cond = ir[31:28];

    always_comb begin
        case (dp_classify(instr))
            CLASS_IMM, CLASS_RSI: entry_state = S_EX;
            CLASS_RSR:            entry_state = S_RS;
            default:              entry_state = S_UND;
        endcase
    end

    always_comb begin
        ex_word                       = CONTROL_ZERO;
        ex_word.alu_op                = alu_op;
        ex_word.set_alu_flags         = set_flags;
        ex_word.alu_writeback         = wb_none ? ALU_WB_NONE : ALU_WB_REG_RD;
        ex_word.addr_bus_src          = ADDR_INCR;
        ex_word.incrementer_writeback = 1'b1;
        ex_word.shift_source          = SHIFT_SRC_IMM;
        if (dp_class == CLASS_IMM) begin
            ex_word.b_bus_source = B_IMM;
            ex_word.b_bus_imm    = ir[11:0];
            ex_word.shift_type   = SHIFT_ROR;
            ex_word.shift_amount = {ir[11:8], 1'b0};
        end else begin
            ex_word.b_bus_source = B_REG_RM;
            ex_word.shift_type   = shift_type_t'(ir[6:5]);
            ex_word.shift_amount = ir[11:7];
        end

        rs_word                       = CONTROL_ZERO;
        rs_word.latch_shift_amt       = 1'b1;
        rs_word.shift_source          = SHIFT_SRC_REG;
        rs_word.addr_bus_src          = ADDR_INCR;
        rs_word.incrementer_writeback = 1'b1;

        ex2_word                 = CONTROL_ZERO;
        ex2_word.alu_op          = alu_op;
        ex2_word.set_alu_flags   = set_flags;
        ex2_word.alu_writeback   = wb_none ? ALU_WB_NONE : ALU_WB_REG_RD;
        ex2_word.b_bus_source    = B_REG_RM;
        ex2_word.shift_source    = SHIFT_SRC_REG;
        ex2_word.use_shift_latch = 1'b1;
        ex2_word.shift_type      = shift_type_t'(ir[6:5]);
    end

    always_comb begin
        next_state  = state;
        control     = CONTROL_ZERO;
        instr_ready = 1'b1;
        flush       = 1'b0;
        undef       = 1'b0;
        case (state)
            S_IDLE: ;
            S_EX, S_EX2: begin
                if (state == S_EX && !cond_pass) begin
                    control = CONTROL_NOP;
                end else begin
                    control = (state == S_EX) ? ex_word : ex2_word;
                    // EX2 inherits the condition result sampled in S_RS.
                    if (rd_is_pc && !wb_none) begin
                        control.addr_bus_src          = ADDR_ALU;
                        control.incrementer_writeback = 1'b0;
                        flush       = 1'b1;
                        instr_ready = 1'b0;
                        next_state  = S_REF1;
                    end
                end
            end
            S_RS: begin
                if (!cond_pass) begin
                    control = CONTROL_NOP;
                end else begin
                    control     = rs_word;
                    instr_ready = 1'b0;
                    next_state  = S_EX2;
                end
            end
            S_UND: begin
                control = CONTROL_NOP;
                undef   = cond_pass;
            end
            S_REF1: begin
                control     = CONTROL_NOP;
                instr_ready = 1'b0;
                next_state  = S_REF2;
            end
            S_REF2:  control = CONTROL_NOP;
            default: next_state = S_IDLE;
        endcase
        if (instr_ready)
            next_state = instr_valid ? entry_state : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (instr_valid && instr_ready)
                ir <= instr;
        end
    end

endmodule

// File: tb/tb_arm7_dp_sequencer.sv
// Directed self-checking bench for the data-processing sequencer.
module tb_arm7_dp_sequencer;
    import arm7_dp_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  cond;
    logic        cond_pass;
    control_t    control;
    logic        flush;
    logic        undef;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDS_IMM = 32'hE29210FF;
    localparam logic [31:0] ADD_RSR  = 32'hE0810312;
    localparam logic [31:0] MOV_PC   = 32'hE1A0F000;
    localparam logic [31:0] CMPNE    = 32'h13500001;
    localparam logic [31:0] MUL      = 32'hE0000091;

    arm7_dp_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .cond        (cond),
        .cond_pass   (cond_pass),
        .control     (control),
        .flush       (flush),
        .undef       (undef)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input control_t ec, input logic er,
                       input logic ef, input logic eu);
        checks++;
        assert (control === ec) else begin
            errors++;
            $error("FAIL %s control got %h exp %h", tag, control, ec);
        end
        checks++;
        assert (instr_ready === er) else begin
            errors++;
            $error("FAIL %s instr_ready got %b exp %b", tag, instr_ready, er);
        end
        checks++;
        assert (flush === ef) else begin
            errors++;
            $error("FAIL %s flush got %b exp %b", tag, flush, ef);
        end
        checks++;
        assert (undef === eu) else begin
            errors++;
            $error("FAIL %s undef got %b exp %b", tag, undef, eu);
        end
    endtask

    function automatic control_t nop_word();
        control_t w;
        w = '0;
        w.addr_bus_src          = ADDR_INCR;
        w.incrementer_writeback = 1'b1;
        return w;
    endfunction

    function automatic control_t adds_word();
        control_t w;
        w = '0;
        w.alu_op                = 4'h4;
        w.set_alu_flags         = 1'b1;
        w.alu_writeback         = ALU_WB_REG_RD;
        w.addr_bus_src          = ADDR_INCR;
        w.incrementer_writeback = 1'b1;
        w.b_bus_source          = B_IMM;
        w.b_bus_imm             = 12'h0FF;
        w.shift_source          = SHIFT_SRC_IMM;
        w.shift_type            = SHIFT_ROR;
        w.shift_amount          = 5'd0;
        return w;
    endfunction

    function automatic control_t rs_word();
        control_t w;
        w = '0;
        w.latch_shift_amt       = 1'b1;
        w.shift_source          = SHIFT_SRC_REG;
        w.addr_bus_src          = ADDR_INCR;
        w.incrementer_writeback = 1'b1;
        return w;
    endfunction

    initial begin
        control_t exp;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        cond_pass   = 1'b1;
        #2;
        chk("reset", control_t'('0), 1'b1, 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;

        // ADDS r1,r2,#0xFF
        instr = ADDS_IMM; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("adds_ex", adds_word(), 1'b1, 1'b0, 1'b0);
        step();
        chk("idle", control_t'('0), 1'b1, 1'b0, 1'b0);

        // ADD r0,r1,r2,LSL r3 with a waiting instruction held off during S_RS
        instr = ADD_RSR; instr_valid = 1'b1;
        step();
        instr = ADDS_IMM;
        chk("rsr_c1", rs_word(), 1'b0, 1'b0, 1'b0);
        instr_valid = 1'b0;
        exp = '0;
        exp.alu_op          = 4'h4;
        exp.alu_writeback   = ALU_WB_REG_RD;
        exp.b_bus_source    = B_REG_RM;
        exp.shift_source    = SHIFT_SRC_REG;
        exp.use_shift_latch = 1'b1;
        exp.shift_type      = SHIFT_LSL;
        step();
        chk("rsr_c2", exp, 1'b1, 1'b0, 1'b0);
        step();
        chk("rsr_idle", control_t'('0), 1'b1, 1'b0, 1'b0);

        // MOV pc,r0 -> flush plus two refill cycles
        instr = MOV_PC; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        exp = '0;
        exp.alu_op        = 4'hD;
        exp.alu_writeback = ALU_WB_REG_RD;
        exp.addr_bus_src  = ADDR_ALU;
        exp.b_bus_source  = B_REG_RM;
        exp.shift_source  = SHIFT_SRC_IMM;
        exp.shift_type    = SHIFT_LSL;
        chk("movpc_ex", exp, 1'b0, 1'b1, 1'b0);
        step();
        chk("movpc_ref1", nop_word(), 1'b0, 1'b0, 1'b0);
        step();
        chk("movpc_ref2", nop_word(), 1'b1, 1'b0, 1'b0);
        step();
        chk("movpc_idle", control_t'('0), 1'b1, 1'b0, 1'b0);

        // CMPNE r0,#1: fail then pass, issued back-to-back
        instr = CMPNE; instr_valid = 1'b1;
        step();
        cond_pass = 1'b0;
        #1;
        checks++;
        assert (cond === 4'h1) else begin
            errors++;
            $error("FAIL cmp_cond cond got %h exp %h", cond, 4'h1);
        end
        chk("cmp_fail", nop_word(), 1'b1, 1'b0, 1'b0);
        cond_pass = 1'b1;
        step();
        instr_valid = 1'b0;
        exp = '0;
        exp.alu_op                = 4'hA;
        exp.set_alu_flags         = 1'b1;
        exp.alu_writeback         = ALU_WB_NONE;
        exp.addr_bus_src          = ADDR_INCR;
        exp.incrementer_writeback = 1'b1;
        exp.b_bus_source          = B_IMM;
        exp.b_bus_imm             = 12'h001;
        exp.shift_source          = SHIFT_SRC_IMM;
        exp.shift_type            = SHIFT_ROR;
        chk("cmp_pass", exp, 1'b1, 1'b0, 1'b0);

        // MUL is undefined here; IMM follows back-to-back
        instr = MUL; instr_valid = 1'b1;
        step();
        instr = ADDS_IMM;
        chk("mul_und", nop_word(), 1'b1, 1'b0, 1'b1);
        step();
        instr_valid = 1'b0;
        chk("after_und", adds_word(), 1'b1, 1'b0, 1'b0);

        // Undefined encoding with failed condition: no undef pulse
        instr = MUL; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        cond_pass = 1'b0;
        #1;
        chk("mul_condfail", nop_word(), 1'b1, 1'b0, 1'b0);
        step();
        cond_pass = 1'b1;

        // RSR with failed condition takes one cycle and skips S_EX2
        instr = ADD_RSR; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        cond_pass = 1'b0;
        #1;
        chk("rsr_fail", nop_word(), 1'b1, 1'b0, 1'b0);
        step();
        cond_pass = 1'b1;
        chk("rsr_fail_idle", control_t'('0), 1'b1, 1'b0, 1'b0);

        // PC write with failed condition never flushes
        instr = MOV_PC; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        cond_pass = 1'b0;
        #1;
        chk("movpc_fail", nop_word(), 1'b1, 1'b0, 1'b0);
        step();
        cond_pass = 1'b1;
        chk("movpc_fail_idle", control_t'('0), 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while in S_RS
        instr = ADD_RSR; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("pre_reset_rs", rs_word(), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_rs", control_t'('0), 1'b1, 1'b0, 1'b0);
        checks++;
        assert (cond === 4'h0) else begin
            errors++;
            $error("FAIL reset_ir cond got %h exp %h", cond, 4'h0);
        end
        #1;
        rst_n = 1'b1;
        step();
        chk("post_reset", control_t'('0), 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
